cpu_mem_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM between two requesters: the CPU data port and a host/debug port.
- The CPU data port has fixed one-cycle read timing and no wait input, so the CPU always has absolute priority.
- The host port uses a req/ack handshake and only gets cycles the CPU leaves idle.
- The block also generates the CPU's active-high reset, so the host can halt the core and load memory.

---
 rtl/cpu_mem_pkg.sv | 12 +
 rtl/cpu_mem_arbiter.sv | 118 +++++++++++
 tb/tb_cpu_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and default bus widths for the CPU memory subsystem.
package cpu_mem_pkg;

  localparam int CPU_AWIDTH = 16;
  localparam int CPU_DWIDTH = 16;

  typedef enum logic {
    IDLE,
    ACK
  } arb_state_t;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Single-port SRAM arbiter: CPU has absolute priority, host uses idle cycles
// through a req/ack handshake. Also drives the CPU reset for host halt.
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AWIDTH       = CPU_AWIDTH,
  parameter int DWIDTH       = CPU_DWIDTH,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] cpu_raddr,
  input  logic              cpu_re,
  output logic [DWIDTH-1:0] cpu_rdata,
  input  logic [AWIDTH-1:0] cpu_waddr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic              cpu_rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AWIDTH-1:0] host_addr,
  input  logic [DWIDTH-1:0] host_wdata,
  output logic              host_ack,
  output logic [DWIDTH-1:0] host_rdata,
  input  logic              host_halt,
  output logic              host_starve,
  output logic              proto_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  arb_state_t state;
  logic       cpu_acc;
  logic       host_issue;
  logic       host_rd_q;
  logic [7:0] starve_cnt;
  logic [7:0] starve_nxt;

  always_comb begin
    cpu_acc    = cpu_re | cpu_we;
    host_issue = (state == IDLE) && host_req && !cpu_acc;
  end

  assign cpu_rdata = mem_rdata;

  // Read data is only meaningful in the ack cycle of a host read; zero otherwise.
  assign host_rdata = (host_ack && host_rd_q) ? mem_rdata : '0;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cpu_raddr;
    mem_wdata = cpu_wdata;
    if (cpu_we) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = cpu_waddr;
    end else if (cpu_re) begin
      mem_en = 1'b1;
    end else if (host_issue) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
    if (!rst_n) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  // Counter holds during ACK so an in-flight access does not reset the history.
  always_comb begin
    starve_nxt = starve_cnt;
    if ((state == IDLE) && host_req && cpu_acc) begin
      starve_nxt = (starve_cnt == 8'hFF) ? starve_cnt : starve_cnt + 8'd1;
    end else if (host_issue || !host_req) begin
      starve_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      host_ack    <= 1'b0;
      host_rd_q   <= 1'b0;
      starve_cnt  <= '0;
      host_starve <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (host_issue) begin
            state     <= ACK;
            host_ack  <= 1'b1;
            host_rd_q <= !host_we;
          end
        end
        ACK: state <= IDLE;
      endcase
      starve_cnt  <= starve_nxt;
      host_starve <= (starve_nxt >= LIMIT);
      if (cpu_re && cpu_we) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpu_rst <= 1'b1;
    else        cpu_rst <= host_halt;
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter with an SRAM model and a host-read
// scoreboard popped on host_ack.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_raddr = '0;
  logic        cpu_re = 1'b0;
  logic [15:0] cpu_rdata;
  logic [15:0] cpu_waddr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_rst;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_halt = 1'b0;
  logic        host_starve;
  logic        proto_err;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  typedef struct {
    logic        rd;
    logic [15:0] data;
  } sb_entry_t;

  sb_entry_t   sb[$];
  logic [15:0] sram    [0:65535];
  logic [15:0] ref_mem [0:65535];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        cpu_pend = 1'b0;
  logic [15:0] cpu_exp  = '0;
  int          lat;

  cpu_mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .STARVE_LIMIT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_raddr(cpu_raddr), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata),
    .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rst(cpu_rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_halt(host_halt), .host_starve(host_starve), .proto_err(proto_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    sb_entry_t e;
    if (rst_n) begin
      if (cpu_pend) check("cpu_rdata", cpu_rdata, cpu_exp);
      if (host_ack) begin
        if (sb.size() == 0) check("host_ack_unexpected", host_ack, 0);
        else begin
          e = sb.pop_front();
          if (e.rd) check("host_rdata", host_rdata, e.data);
        end
      end
    end
    cpu_pend = rst_n && cpu_re && !cpu_we;
    cpu_exp  = ref_mem[cpu_raddr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    sb_entry_t e;
    e.rd   = !we;
    e.data = ref_mem[addr];
    sb.push_back(e);
    if (we) ref_mem[addr] = wd;
  endtask

  task automatic host_xfer(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                           output int lat_o);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wd;
    push_exp(we, addr, wd);
    lat_o = 0;
    do begin
      cyc();
      lat_o++;
    end while (!host_ack && lat_o < 100);
    if (!host_ack) check("host_ack_timeout", host_ack, 1);
    host_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset, with a CPU read strobe present to prove mem_en is gated.
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    cpu_re = 1'b1;
    #2;
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_mem_en", mem_en, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_host_starve", host_starve, 0);
    check("rst_proto_err", proto_err, 0);
    repeat (3) @(posedge clk);
    #1;
    cpu_re = 1'b0;
    rst_n  = 1'b1;
    #1 check("rel_cpu_rst_hold", cpu_rst, 1);
    cyc();
    check("rel_cpu_rst_fall", cpu_rst, 0);

    // Host write with CPU idle: issue this cycle, ack next.
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 16'hBEEF;
    push_exp(1'b1, 16'h0010, 16'hBEEF);
    #1;
    check("hw_mem_en", mem_en, 1);
    check("hw_mem_we", mem_we, 1);
    check("hw_mem_addr", mem_addr, 16'h0010);
    check("hw_mem_wdata", mem_wdata, 16'hBEEF);
    cyc();
    check("hw_ack", host_ack, 1);
    host_req = 1'b0;
    cyc();
    check("hw_ack_pulse", host_ack, 0);
    host_xfer(1'b0, 16'h0010, '0, lat);
    check("hr_latency", lat, 1);
    host_xfer(1'b1, 16'h0020, 16'h5A5A, lat);

    // CPU read collides with host read: CPU wins, host issues one cycle later.
    cyc();
    cpu_re = 1'b1; cpu_raddr = 16'h0010;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
    push_exp(1'b0, 16'h0020, '0);
    #1;
    check("col_mem_addr_cpu", mem_addr, 16'h0010);
    check("col_mem_we", mem_we, 0);
    cyc();
    cpu_re = 1'b0;
    #1;
    check("col_host_issue_addr", mem_addr, 16'h0020);
    check("col_no_ack_yet", host_ack, 0);
    cyc();
    check("col_ack", host_ack, 1);
    host_req = 1'b0;
    cyc();

    // Starvation: CPU reads back-to-back for 70 cycles while host waits.
    cpu_re = 1'b1; cpu_raddr = 16'h0010;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
    push_exp(1'b0, 16'h0020, '0);
    for (int i = 1; i <= 70; i++) begin
      cyc();
      if (i == 1 || i == 63) check("starve_low", host_starve, 0);
      if (i == 64 || i == 70) check("starve_high", host_starve, 1);
      if (i == 70) check("starve_no_ack", host_ack, 0);
    end
    cpu_re = 1'b0;
    #1;
    check("starve_issue_addr", mem_addr, 16'h0020);
    check("starve_still_high", host_starve, 1);
    cyc();
    check("starve_cleared", host_starve, 0);
    check("starve_ack", host_ack, 1);
    host_req = 1'b0;
    cyc();

    // Simultaneous CPU read and write: write wins, proto_err sticks.
    cpu_re = 1'b1; cpu_we = 1'b1;
    cpu_raddr = 16'h0005; cpu_waddr = 16'h0005; cpu_wdata = 16'h1234;
    ref_mem[16'h0005] = 16'h1234;
    #1;
    check("pe_mem_we", mem_we, 1);
    check("pe_mem_addr", mem_addr, 16'h0005);
    check("pe_mem_wdata", mem_wdata, 16'h1234);
    cyc();
    cpu_we = 1'b0;
    check("pe_set", proto_err, 1);
    cyc();
    cpu_re = 1'b0;
    repeat (5) cyc();
    check("pe_sticky", proto_err, 1);

    // Halted CPU: back-to-back host accesses at full bandwidth.
    host_halt = 1'b1;
    #1 check("halt_not_yet", cpu_rst, 0);
    cyc();
    check("halt_cpu_rst", cpu_rst, 1);
    for (int i = 0; i < 4; i++) begin
      host_xfer(1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i), lat);
      check("halt_wr_lat", lat, (i == 0) ? 1 : 2);
    end
    for (int i = 0; i < 4; i++) begin
      host_xfer(1'b0, 16'h0100 + 16'(i), '0, lat);
      check("halt_rd_lat", lat, 2);
      check("halt_cpu_rst_held", cpu_rst, 1);
    end
    host_halt = 1'b0;
    #1 check("unhalt_hold", cpu_rst, 1);
    cyc();
    check("unhalt_fall", cpu_rst, 0);

    // Reset while an access is in ACK: no ack, state and flags cleared.
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
    cyc();
    rst_n = 1'b0;
    #1;
    check("mid_rst_no_ack", host_ack, 0);
    check("mid_rst_cpu_rst", cpu_rst, 1);
    check("mid_rst_proto_err", proto_err, 0);
    check("mid_rst_mem_en", mem_en, 0);
    host_req = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1 check("mid_rel_cpu_rst", cpu_rst, 1);
    cyc();
    check("mid_rel_cpu_rst_fall", cpu_rst, 0);
    check("mid_rel_no_ack", host_ack, 0);
    repeat (2) cyc();
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
